seq_det_param: RTL and testbench
================================

SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 Parameter PAT_LEN, default 8, SHALL set the maximum pattern length in bits (legal 2..16).
REQ-002 Parameter CNT_W, default 8, SHALL set the match-counter width (legal 1..16).
REQ-003 Parameter OVERLAP, default 1, SHALL select overlapping (1) or non-overlapping (0) detection.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_b  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  detector enable.
REQ-007 load  in  1  pattern/length load strobe.
REQ-008 pat_in  in  PAT_LEN  pattern; bit len-1 = first bit received, bit 0 = last.
REQ-009 len_in  in  $clog2(PAT_LEN+1)  active pattern length.
REQ-010 din  in  1  serial data bit.
REQ-011 din_vld  in  1  din qualifier.
REQ-012 clr_cnt  in  1  synchronous match-counter clear.
REQ-013 match  out  1  match pulse.
REQ-014 match_cnt  out  CNT_W  saturating match count.
REQ-015 cnt_sat  out  1  high while match_cnt is all ones.
REQ-016 state  out  2  FSM state: IDLE=00, FILL=01, RUN=10.

Function
REQ-017 A bit SHALL be accepted only in a cycle with en=1, din_vld=1 and load=0.
REQ-018 On an accepted bit, the window SHALL shift as {window[PAT_LEN-2:0], din}, and fill SHALL increment, saturating at PAT_LEN.
REQ-019 load SHALL capture pat_in and the effective length in one cycle, clear window and fill, and take priority over any bit arriving in that cycle.
REQ-020 The effective length SHALL be: len_in=0 -> 1; len_in>PAT_LEN -> PAT_LEN; otherwise len_in.
REQ-021 A hit SHALL occur on an accepted bit when fill+1>=len and the low len bits of {window,din} equal the low len bits of the stored pattern.
REQ-022 The FSM SHALL transition: IDLE->FILL when en=1; FILL->RUN when fill reaches len; any state->IDLE when en=0; load or a non-overlapping hit -> FILL.
REQ-023 On entry to IDLE, window and fill SHALL clear.
REQ-024 When OVERLAP=1, a hit SHALL leave the FSM in RUN with the window retained.
REQ-025 When OVERLAP=0, a hit SHALL clear fill and move the FSM to FILL, so no pattern bit is reused.
REQ-026 match SHALL be 0 whenever en=0 or no hit occurs.
REQ-027 match_cnt SHALL increment by 1 per match pulse and saturate at 2^CNT_W-1 without wrapping.
REQ-028 When clr_cnt and a match coincide, clr_cnt SHALL win and match_cnt SHALL become 0.
REQ-029 Cycles with din_vld=0 SHALL hold all state, window and fill unchanged.

Reset
REQ-030 While rst_b=0, the block SHALL force: state=IDLE, window=0, fill=0, stored pattern=0, stored length=PAT_LEN, match=0, match_cnt=0, cnt_sat=0.
REQ-031 Reset asserted mid-sequence SHALL discard any partial match; after reset, detection SHALL restart from an empty window.

Configuration
REQ-032 Macro SEQ_DET_MOORE_EN SHALL be the single compile-time option.
REQ-033 Without SEQ_DET_MOORE_EN (Mealy), match SHALL be combinational and high in the same cycle as the accepted bit completing the pattern.
REQ-034 With SEQ_DET_MOORE_EN (Moore), match SHALL be registered and high exactly one cycle after that bit, for one cycle.
REQ-035 In both builds, match_cnt SHALL update on the clock edge ending the cycle in which match is high.

Verification
REQ-036 Overlap: OVERLAP=1, load pat=1011, len=4, en=1, din 1,0,1,1,0,1,1 back-to-back -> match on bits 4 and 7, match_cnt=2.
REQ-037 Non-overlap: same stimulus with OVERLAP=0 -> match on bit 4 only, match_cnt=1, state=FILL after bit 7.
REQ-038 Gaps and clamp: len_in=0 with pat bit0=1, din_vld toggled every other cycle on stream 1,1 -> two matches; no state change in idle cycles.
REQ-039 Saturation and clear: CNT_W=2, five matches -> match_cnt=3 with cnt_sat=1; clr_cnt coinciding with a match -> match_cnt=0.
REQ-040 Reset mid-operation: rst_b low after 3 of 4 pattern bits -> state=IDLE, match_cnt=0; last bit alone after release -> no match.
REQ-041 Moore build: SEQ_DET_MOORE_EN defined, REQ-036 stimulus -> match delayed exactly one cycle versus the Mealy build, same count.

Source files
------------

// File: rtl/seq_det_param.sv
// Parameterised serial pattern detector with programmable length, overlap mode and saturating match counter.
// Compile-time option SEQ_DET_MOORE_EN selects a registered (Moore) match output; default is Mealy.
module seq_det_param #(
  parameter int unsigned PAT_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned OVERLAP = 1
) (
  input  logic                           clk,
  input  logic                           rst_b,
  input  logic                           en,
  input  logic                           load,
  input  logic [PAT_LEN-1:0]             pat_in,
  input  logic [$clog2(PAT_LEN+1)-1:0]   len_in,
  input  logic                           din,
  input  logic                           din_vld,
  input  logic                           clr_cnt,
  output logic                           match,
  output logic [CNT_W-1:0]               match_cnt,
  output logic                           cnt_sat,
  output logic [1:0]                     state
);

  localparam int unsigned LW = $clog2(PAT_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    RUN  = 2'b10
  } state_e;

  state_e             cur, nxt;
  logic [PAT_LEN-1:0] window, pat_reg, shifted, mask;
  logic [LW-1:0]      fill, len_reg, len_eff, fill_inc;
  logic               accept, hit;

  assign accept  = en & din_vld & ~load;
  assign shifted = {window[PAT_LEN-2:0], din};

  always_comb begin
    len_eff = len_in;
    if (len_in == '0)
      len_eff = LW'(1);
    else if (len_in > LW'(PAT_LEN))
      len_eff = LW'(PAT_LEN);
  end

  // fill saturates at PAT_LEN, so (fill_inc >= len) is equivalent to (fill+1 >= len)
  assign fill_inc = (fill == LW'(PAT_LEN)) ? fill : fill + 1'b1;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PAT_LEN; i++)
      mask[i] = (i < 32'(len_reg));
  end

  assign hit = accept && (fill_inc >= len_reg) && (((shifted ^ pat_reg) & mask) == '0);

  always_comb begin
    nxt = cur;
    if (!en)
      nxt = IDLE;
    else if (load)
      nxt = FILL;
    else if (hit)
      nxt = (OVERLAP != 0) ? RUN : FILL;
    else if (accept)
      nxt = (fill_inc >= len_reg) ? RUN : FILL;
    else if (cur == IDLE)
      nxt = FILL;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      cur <= IDLE;
    else
      cur <= nxt;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      window  <= '0;
      fill    <= '0;
      pat_reg <= '0;
      len_reg <= LW'(PAT_LEN);
    end else begin
      if (load) begin
        pat_reg <= pat_in;
        len_reg <= len_eff;
      end
      if (!en || load) begin
        window <= '0;
        fill   <= '0;
      end else if (accept) begin
        window <= shifted;
        // non-overlapping hit restarts the fill count so no matched bit is reused
        fill   <= (hit && OVERLAP == 0) ? '0 : fill_inc;
      end
    end
  end

`ifdef SEQ_DET_MOORE_EN
  logic match_r;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      match_r <= 1'b0;
    else
      match_r <= hit;
  end

  assign match = match_r & en;
`else
  assign match = hit;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      match_cnt <= '0;
    else if (clr_cnt)
      match_cnt <= '0;
    else if (match && !(&match_cnt))
      match_cnt <= match_cnt + 1'b1;
  end

  assign cnt_sat = &match_cnt;
  assign state   = cur;

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: an overlapping/CNT_W=2 instance and a non-overlapping instance share stimulus.
// Expected match cycles are queued by the driver and popped by a negedge monitor.
module tb_seq_det_param;

`ifdef SEQ_DET_MOORE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk, rst_b, en, load, din, din_vld, clr_cnt;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic       m_ov, m_no, sat_ov, sat_no;
  logic [1:0] cnt_ov;
  logic [7:0] cnt_no;
  logic [1:0] st_ov, st_no;

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;
  int q_ov[$];
  int q_no[$];

  seq_det_param #(.PAT_LEN(8), .CNT_W(2), .OVERLAP(1)) dut_ov (
    .clk(clk), .rst_b(rst_b), .en(en), .load(load), .pat_in(pat_in), .len_in(len_in),
    .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
    .match(m_ov), .match_cnt(cnt_ov), .cnt_sat(sat_ov), .state(st_ov)
  );

  seq_det_param #(.PAT_LEN(8), .CNT_W(8), .OVERLAP(0)) dut_no (
    .clk(clk), .rst_b(rst_b), .en(en), .load(load), .pat_in(pat_in), .len_in(len_in),
    .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
    .match(m_no), .match_cnt(cnt_no), .cnt_sat(sat_no), .state(st_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every observed match must be the next one predicted for that instance
  always @(negedge clk) begin
    if (m_ov) begin
      int e;
      e = (q_ov.size() > 0) ? q_ov.pop_front() : -1;
      chk("ov_match_cycle", cyc, e);
    end
    if (m_no) begin
      int e;
      e = (q_no.size() > 0) ? q_no.pop_front() : -1;
      chk("no_match_cycle", cyc, e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    din_vld = 1'b0;
    tick();
  endtask

  task automatic bit_in(input logic d, input bit exp_ov, input bit exp_no, input logic clr);
    din     = d;
    din_vld = 1'b1;
    clr_cnt = clr;
    if (exp_ov) q_ov.push_back(cyc + LAT);
    if (exp_no) q_no.push_back(cyc + LAT);
    tick();
    din_vld = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l);
    pat_in = p;
    len_in = l;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0; en = 1'b0; load = 1'b0; din = 1'b0; din_vld = 1'b0; clr_cnt = 1'b0;
    pat_in = '0; len_in = '0;
    tick(); tick();

    chk("rst_state_ov", int'(st_ov), 0);
    chk("rst_state_no", int'(st_no), 0);
    chk("rst_cnt_ov", int'(cnt_ov), 0);
    chk("rst_cnt_no", int'(cnt_no), 0);
    chk("rst_sat_ov", int'(sat_ov), 0);
    chk("rst_sat_no", int'(sat_no), 0);
    chk("rst_match_ov", int'(m_ov), 0);
    chk("rst_match_no", int'(m_no), 0);

    rst_b = 1'b1;
    tick();
    en = 1'b1;
    idle();
    chk("idle_to_fill_ov", int'(st_ov), 1);
    chk("idle_to_fill_no", int'(st_no), 1);

    // Overlap vs non-overlap: pattern 1011, stream 1,0,1,1,0,1,1
    do_load(8'b0000_1011, 4'd4);
    chk("load_state_ov", int'(st_ov), 1);
    bit_in(1'b1, 0, 0, 1'b0);
    bit_in(1'b0, 0, 0, 1'b0);
    bit_in(1'b1, 0, 0, 1'b0);
    bit_in(1'b1, 1, 1, 1'b0);
    bit_in(1'b0, 0, 0, 1'b0);
    bit_in(1'b1, 0, 0, 1'b0);
    bit_in(1'b1, 1, 0, 1'b0);
    chk("ovl_state_ov", int'(st_ov), 2);
    chk("ovl_state_no", int'(st_no), 1);
    idle();
    chk("ovl_cnt_ov", int'(cnt_ov), 2);
    chk("ovl_cnt_no", int'(cnt_no), 1);

    // Length clamp (len_in=0 -> 1) with din_vld gaps
    do_load(8'h01, 4'd0);
    bit_in(1'b1, 1, 1, 1'b0);
    idle();
    chk("gap1_state_ov", int'(st_ov), 2);
    chk("gap1_state_no", int'(st_no), 1);
    bit_in(1'b1, 1, 1, 1'b0);
    idle();
    chk("gap2_state_ov", int'(st_ov), 2);
    chk("gap2_state_no", int'(st_no), 1);
    chk("gap_cnt_no", int'(cnt_no), 3);
    chk("sat4_cnt_ov", int'(cnt_ov), 3);
    chk("sat4_flag_ov", int'(sat_ov), 1);
    bit_in(1'b0, 0, 0, 1'b0);
    bit_in(1'b1, 1, 1, 1'b0);
    idle();
    chk("sat5_cnt_ov", int'(cnt_ov), 3);
    chk("sat5_flag_ov", int'(sat_ov), 1);
    chk("sat5_flag_no", int'(sat_no), 0);
    chk("cnt5_no", int'(cnt_no), 4);

    // clr_cnt in the same cycle the match is presented
    if (LAT == 0) begin
      bit_in(1'b1, 1, 1, 1'b1);
    end else begin
      bit_in(1'b1, 1, 1, 1'b0);
      clr_cnt = 1'b1;
      idle();
      clr_cnt = 1'b0;
    end
    idle();
    chk("clr_cnt_ov", int'(cnt_ov), 0);
    chk("clr_sat_ov", int'(sat_ov), 0);
    chk("clr_cnt_no", int'(cnt_no), 0);

    // Reset mid-sequence after one full match and a 3-bit partial
    do_load(8'b0000_1011, 4'd4);
    bit_in(1'b1, 0, 0, 1'b0);
    bit_in(1'b0, 0, 0, 1'b0);
    bit_in(1'b1, 0, 0, 1'b0);
    bit_in(1'b1, 1, 1, 1'b0);
    bit_in(1'b1, 0, 0, 1'b0);
    bit_in(1'b0, 0, 0, 1'b0);
    bit_in(1'b1, 0, 0, 1'b0);
    chk("pre_rst_cnt_ov", int'(cnt_ov), 1);
    chk("pre_rst_cnt_no", int'(cnt_no), 1);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rst_state_ov", int'(st_ov), 0);
    chk("mid_rst_state_no", int'(st_no), 0);
    chk("mid_rst_cnt_ov", int'(cnt_ov), 0);
    chk("mid_rst_cnt_no", int'(cnt_no), 0);
    tick();
    rst_b = 1'b1;
    bit_in(1'b1, 0, 0, 1'b0);
    idle();
    chk("post_rst_cnt_ov", int'(cnt_ov), 0);
    chk("post_rst_cnt_no", int'(cnt_no), 0);

    en = 1'b0;
    idle();
    chk("en_off_state_ov", int'(st_ov), 0);
    chk("en_off_state_no", int'(st_no), 0);
    idle();

    chk("ov_pending", q_ov.size(), 0);
    chk("no_pending", q_no.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
